ldpc_cyclic_shift_pipe: RTL and testbench

Parametrised, pipelined cyclic rotator with a valid/ready handshake, runtime rotate direction, modulo reduction of the shift amount, and a sideband tag carried alongside the data. It is the next generation of the encoder's fixed-direction, handshake-free barrel rotator. It sits between the parity-address generator and the parity accumulator RAM, and aligns 360-bit (or other WIDTH) circulant words to the accumulator lanes. Backpressure from the accumulator stalls the whole pipe without losing or duplicating words.

---
 rtl/ldpc_pkg.sv | 31 +++
 rtl/ldpc_cyclic_shift_stage.sv | 59 +++++
 rtl/ldpc_cyclic_shift_pipe.sv | 111 +++++++++++
 tb/tb_ldpc_cyclic_shift_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC constants and rotate helpers
package ldpc_pkg;

    localparam int LDPC_Z       = 360;
    localparam int LDPC_SHIFT_W = 9;
    localparam int ROTR_MAX_W   = 512;
    localparam int ROTR_IDX_W   = $clog2(ROTR_MAX_W);

    function automatic int popcount(input logic [31:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // Right rotate of the low w bits of d by amt; bits at and above w read as zero.
    function automatic logic [ROTR_MAX_W-1:0] rotr(input logic [ROTR_MAX_W-1:0] d,
                                                   input int amt, input int w);
        logic [ROTR_MAX_W-1:0] r;
        r = '0;
        for (int j = 0; j < ROTR_MAX_W; j++) begin
            if (j < w) begin
                r[ROTR_IDX_W'(j)] = d[ROTR_IDX_W'((j + amt) % w)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ldpc_cyclic_shift_stage.sv
// rtl/ldpc_cyclic_shift_stage.sv - one conditional rotate-right stage, optionally registered
module ldpc_cyclic_shift_stage
    import ldpc_pkg::*;
#(
    parameter int WIDTH           = LDPC_Z,
    parameter int TAG_WIDTH       = 16,
    parameter int SHIFT_VAL_WIDTH = LDPC_SHIFT_W,
    parameter int AMOUNT          = 1,
    parameter int REG             = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       up_valid,
    input  logic [WIDTH-1:0]           up_data,
    input  logic [TAG_WIDTH-1:0]       up_tag,
    input  logic [SHIFT_VAL_WIDTH-1:0] up_shift,
    output logic                       dn_valid,
    output logic [WIDTH-1:0]           dn_data,
    output logic [TAG_WIDTH-1:0]       dn_tag,
    output logic [SHIFT_VAL_WIDTH-1:0] dn_shift
);

    localparam int BIT = $clog2(AMOUNT);
    localparam int AMT = AMOUNT % WIDTH;

    logic [WIDTH-1:0] rot_data;

    // An amount equal to WIDTH is an identity rotate (and unreachable since e < WIDTH).
    if (AMT == 0) begin : g_nop
        assign rot_data = up_data;
    end else begin : g_rot
        assign rot_data = up_shift[BIT] ? {up_data[AMT-1:0], up_data[WIDTH-1:AMT]} : up_data;
    end

    if (REG != 0) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dn_valid <= 1'b0;
                dn_data  <= '0;
                dn_tag   <= '0;
                dn_shift <= '0;
            end else if (en) begin
                dn_valid <= up_valid;
                dn_data  <= rot_data;
                dn_tag   <= up_tag;
                dn_shift <= up_shift;
            end
        end
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst_n, en};
        assign dn_valid   = up_valid;
        assign dn_data    = rot_data;
        assign dn_tag     = up_tag;
        assign dn_shift   = up_shift;
    end

endmodule

// File: rtl/ldpc_cyclic_shift_pipe.sv
// rtl/ldpc_cyclic_shift_pipe.sv - pipelined cyclic rotator with valid/ready, direction and tag
module ldpc_cyclic_shift_pipe
    import ldpc_pkg::*;
#(
    parameter int          WIDTH           = LDPC_Z,
    parameter int          SHIFT_VAL_WIDTH = LDPC_SHIFT_W,
    parameter logic [31:0] REG_EN          = 32'h124,
    parameter int          TAG_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [SHIFT_VAL_WIDTH-1:0] in_shift,
    input  logic                       in_dir,
    input  logic [TAG_WIDTH-1:0]       in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_WIDTH-1:0]       out_tag
);

    localparam int          SW       = SHIFT_VAL_WIDTH;
    localparam logic [31:0] REG_MASK = REG_EN & ((32'd1 << SW) - 32'd1);
    localparam int          L        = popcount(REG_MASK);
    localparam logic [SW:0] W_EXT    = (SW + 1)'(WIDTH);

    if (WIDTH > (1 << SW) || (1 << SW) > 2 * WIDTH) begin : g_bad_param
        $error("ldpc_cyclic_shift_pipe: need WIDTH <= 2**SHIFT_VAL_WIDTH <= 2*WIDTH");
    end

    logic [SW:0]   s_ext;
    logic [SW:0]   s_red;
    logic [SW:0]   e_ext;
    logic [SW-1:0] e;
    logic          en;
    logic          unused_e_msb;
    logic          unused_shift;

    // One conditional subtract suffices because in_shift < 2*WIDTH; left becomes WIDTH - s_r.
    always_comb begin
        s_ext = {1'b0, in_shift};
        s_red = (s_ext >= W_EXT) ? (s_ext - W_EXT) : s_ext;
        e_ext = s_red;
        if (in_dir && (s_red != '0)) begin
            e_ext = W_EXT - s_red;
        end
    end

    assign e            = e_ext[SW-1:0];
    assign unused_e_msb = e_ext[SW];

    for (genvar i = 0; i < SW; i++) begin : g_stage
        logic                 src_valid;
        logic [WIDTH-1:0]     src_data;
        logic [TAG_WIDTH-1:0] src_tag;
        logic [SW-1:0]        src_shift;
        logic                 stage_valid;
        logic [WIDTH-1:0]     stage_data;
        logic [TAG_WIDTH-1:0] stage_tag;
        logic [SW-1:0]        stage_shift;

        if (i == 0) begin : g_head
            assign src_valid = in_valid;
            assign src_data  = in_data;
            assign src_tag   = in_tag;
            assign src_shift = e;
        end else begin : g_link
            assign src_valid = g_stage[i-1].stage_valid;
            assign src_data  = g_stage[i-1].stage_data;
            assign src_tag   = g_stage[i-1].stage_tag;
            assign src_shift = g_stage[i-1].stage_shift;
        end

        ldpc_cyclic_shift_stage #(
            .WIDTH          (WIDTH),
            .TAG_WIDTH      (TAG_WIDTH),
            .SHIFT_VAL_WIDTH(SW),
            .AMOUNT         (1 << i),
            .REG            (int'((REG_MASK >> i) & 32'd1))
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .up_valid(src_valid),
            .up_data (src_data),
            .up_tag  (src_tag),
            .up_shift(src_shift),
            .dn_valid(stage_valid),
            .dn_data (stage_data),
            .dn_tag  (stage_tag),
            .dn_shift(stage_shift)
        );
    end

    assign out_valid    = g_stage[SW-1].stage_valid;
    assign out_data     = g_stage[SW-1].stage_data;
    assign out_tag      = g_stage[SW-1].stage_tag;
    assign unused_shift = ^g_stage[SW-1].stage_shift;

    // Whole pipe advances together; a held output freezes every register.
    assign en = out_ready | ~out_valid;

    if (L == 0) begin : g_ready_comb
        assign in_ready = out_ready;
    end else begin : g_ready_pipe
        assign in_ready = en;
    end

endmodule

// File: tb/tb_ldpc_cyclic_shift_pipe.sv
// tb/tb_ldpc_cyclic_shift_pipe.sv - scoreboard bench for ldpc_cyclic_shift_pipe
module tb_ldpc_cyclic_shift_pipe;
    import ldpc_pkg::*;

    localparam int W  = LDPC_Z;
    localparam int SW = LDPC_SHIFT_W;
    localparam int TW = 16;

    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct {
        logic [15:0]   data;
        logic [TW-1:0] tag;
        int            cyc;
    } exp16_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_dir, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [SW-1:0] in_shift;
    logic [TW-1:0] in_tag, out_tag;

    logic          s_valid, s_dir, z_ready, z_in_ready, z_out_valid, f_in_ready, f_out_valid;
    logic [15:0]   s_data, z_data, f_data;
    logic [3:0]    s_shift;
    logic [TW-1:0] s_tag, z_tag, f_tag;

    exp_t   q[$];
    exp16_t q16[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     n_out = 0;
    bit     bp_on = 1'b0;
    bit     stall_all = 1'b0;

    ldpc_cyclic_shift_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shift(in_shift), .in_dir(in_dir), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    ldpc_cyclic_shift_pipe #(.WIDTH(16), .SHIFT_VAL_WIDTH(4), .REG_EN(32'h0), .TAG_WIDTH(TW)) u_sw0 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(z_in_ready), .in_data(s_data),
        .in_shift(s_shift), .in_dir(s_dir), .in_tag(s_tag), .out_valid(z_out_valid),
        .out_ready(z_ready), .out_data(z_data), .out_tag(z_tag)
    );

    ldpc_cyclic_shift_pipe #(.WIDTH(16), .SHIFT_VAL_WIDTH(4), .REG_EN(32'hF), .TAG_WIDTH(TW)) u_sw4 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(f_in_ready), .in_data(s_data),
        .in_shift(s_shift), .in_dir(s_dir), .in_tag(s_tag), .out_valid(f_out_valid),
        .out_ready(1'b1), .out_data(f_data), .out_tag(f_tag)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_word(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_int(input string name, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    // Independent model: reduce by modulo, express left as a right rotate by (w - s) mod w.
    function automatic logic [ROTR_MAX_W-1:0] exp_rot(input logic [ROTR_MAX_W-1:0] d, input int s,
                                                      input logic dir, input int w);
        int amt;
        amt = s % w;
        if (dir) amt = (w - amt) % w;
        return rotr(d, amt, w);
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [383:0] r;
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom();
        return r[W-1:0];
    endfunction

    // Called at a falling edge; returns at the falling edge after the word is accepted.
    task automatic send(input logic [W-1:0] d, input int s, input logic dir, input logic [TW-1:0] tag,
                        input logic [W-1:0] exp, output int waits);
        exp_t e;
        in_data  = d;
        in_shift = SW'(s);
        in_dir   = dir;
        in_tag   = tag;
        in_valid = 1'b1;
        waits    = 0;
        #1;
        while (!in_ready && waits < 200) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check_bit("accept_within_bound", in_ready, 1'b1);
        if (in_ready) begin
            e.data = exp;
            e.tag  = tag;
            q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((q.size() != 0 || q16.size() != 0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_int(name, q.size() + q16.size(), 0);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            out_ready = stall_all ? 1'b0 : (bp_on ? ($urandom_range(99) >= 30) : 1'b1);
        end
    end

    initial begin
        logic          prev_stall;
        logic [W-1:0]  pd;
        logic [TW-1:0] pt;
        exp_t          e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_bit("hold_valid", out_valid, 1'b1);
                    check_word("hold_data", out_data, pd);
                    check_int("hold_tag", int'(out_tag), int'(pt));
                end
                if (out_valid && out_ready) begin
                    n_cmp++;
                    assert (q.size() > 0) else begin
                        n_bad++;
                        $error("FAIL stray_out: observed tag %h with empty scoreboard expected none", out_tag);
                    end
                    if (q.size() > 0) begin
                        e = q.pop_front();
                        check_word("out_data", out_data, e.data);
                        check_int("out_tag", int'(out_tag), int'(e.tag));
                    end
                    n_out++;
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                pt = out_tag;
            end
        end
    end

    initial begin
        exp16_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && f_out_valid) begin
                n_cmp++;
                assert (q16.size() > 0) else begin
                    n_bad++;
                    $error("FAIL sw4_stray: observed tag %h with empty scoreboard expected none", f_tag);
                end
                if (q16.size() > 0) begin
                    e = q16.pop_front();
                    check_int("sw4_data", int'(f_data), int'(e.data));
                    check_int("sw4_tag", int'(f_tag), int'(e.tag));
                    check_int("sw4_latency", cyc - e.cyc, 4);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w, hot;
        int           waits, stalls, base, s;
        logic         dir;
        exp16_t       e16;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0; in_tag = '0;
        s_valid = 1'b0; s_data = '0; s_shift = '0; s_dir = 1'b0; s_tag = '0; z_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_word("rst_out_data", out_data, '0);
        check_int("rst_out_tag", int'(out_tag), 0);
        check_bit("rst_sw4_valid", f_out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_bit("idle_in_ready", in_ready, 1'b1);
        @(negedge clk);

        // Single word: bit 0 rotated right by 1 lands in bit 359, three cycles later.
        hot = '0; hot[W-1] = 1'b1;
        send(W'(1), 1, 1'b0, 16'h1234, hot, waits);
        for (int i = 0; i < 2; i++) begin
            #1 check_bit("lat_early", out_valid, 1'b0);
            @(negedge clk);
        end
        #1 check_bit("lat_exact", out_valid, 1'b1);
        check_word("lat_data", out_data, hot);
        check_int("lat_tag", int'(out_tag), 16'h1234);
        @(negedge clk);
        drain("drain_single");

        hot = '0; hot[5] = 1'b1;
        send(W'(1), 365, 1'b1, 16'h0001, hot, waits);
        send(W'(1), 360, 1'b1, 16'h0002, W'(1), waits);
        w = rand_word();
        send(w, 360, 1'b0, 16'h0003, w, waits);
        send(w, 0, 1'b1, 16'h0004, w, waits);
        send(w, 511, 1'b0, 16'h0005, W'(exp_rot(512'(w), 511, 1'b0, W)), waits);
        send(w, 511, 1'b1, 16'h0006, W'(exp_rot(512'(w), 511, 1'b1, W)), waits);
        drain("drain_directed");

        base = n_out; stalls = 0;
        for (int i = 0; i < 1000; i++) begin
            w = rand_word(); s = $urandom_range(511); dir = 1'($urandom_range(1));
            send(w, s, dir, TW'(i), W'(exp_rot(512'(w), s, dir, W)), waits);
            stalls += waits;
        end
        check_int("fullrate_stalls", stalls, 0);
        drain("drain_fullrate");
        check_int("fullrate_count", n_out - base, 1000);

        bp_on = 1'b1; base = n_out;
        for (int i = 0; i < 1000; i++) begin
            w = rand_word(); s = $urandom_range(511); dir = 1'($urandom_range(1));
            send(w, s, dir, TW'(16'h8000 + i), W'(exp_rot(512'(w), s, dir, W)), waits);
        end
        bp_on = 1'b0;
        drain("drain_backpressure");
        check_int("bp_count", n_out - base, 1000);

        // Fill the stalled pipe with three words, then reset with them in flight.
        stall_all = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            send(w, i, 1'b0, TW'(16'hDEA0 + i), W'(exp_rot(512'(w), i, 1'b0, W)), waits);
        end
        #1 check_bit("pre_rst_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_bit("midrst_valid", out_valid, 1'b0);
        check_word("midrst_data", out_data, '0);
        q.delete();
        stall_all = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        #1 check_bit("post_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            w = rand_word();
            send(w, 7 + i, 1'b1, TW'(16'h0B00 + i), W'(exp_rot(512'(w), 7 + i, 1'b1, W)), waits);
        end
        drain("drain_post_rst");
        repeat (5) @(negedge clk);
        check_int("post_rst_count", n_out - base, 2);

        // Exhaustive s/dir on the 16-bit instances: L = 0 checked combinationally, L = 4 via scoreboard.
        for (int d = 0; d < 2; d++) begin
            for (int sh = 0; sh < 16; sh++) begin
                s_valid = 1'b1; s_data = 16'($urandom()); s_shift = 4'(sh); s_dir = 1'(d);
                s_tag = TW'(d * 16 + sh);
                #1;
                e16.data = 16'(exp_rot(512'(s_data), sh, 1'(d), 16));
                e16.tag  = s_tag;
                e16.cyc  = cyc;
                check_int("sw0_data", int'(z_data), int'(e16.data));
                check_int("sw0_tag", int'(z_tag), int'(e16.tag));
                check_bit("sw0_valid", z_out_valid, 1'b1);
                check_bit("sw4_in_ready", f_in_ready, 1'b1);
                if (f_in_ready) q16.push_back(e16);
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
        #1 check_bit("sw0_idle_valid", z_out_valid, 1'b0);
        s_valid = 1'b1; z_ready = 1'b0;
        #1 check_bit("sw0_ready_follows", z_in_ready, 1'b0);
        z_ready = 1'b1;
        #1 check_bit("sw0_ready_high", z_in_ready, 1'b1);
        s_valid = 1'b0;
        @(negedge clk);
        drain("drain_sweep");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
